// File: rtl/clock_frequency_multiplier.sv
// rtl/clock_frequency_multiplier.sv - behavioural ideal clock multiplier, bursts re-launched on every reference edge
`timescale 1ns/1fs
module clock_frequency_multiplier #(
  parameter int MULTIPLICATION = 2
) (
  input  logic clock_in,
  input  logic resetn,
  output logic clock_out
);

  localparam logic [1:0] ST_UNLOCKED  = 2'd0;
  localparam logic [1:0] ST_MEASURING = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;

  if (MULTIPLICATION < 1) begin : g_bad_mult
    $fatal(1, "clock_frequency_multiplier: MULTIPLICATION must be >= 1");
  end

  logic [1:0]  state_q;
  realtime     period_q;
  realtime     stamp_q;
  int unsigned burst_id_q;
  logic        out_q;

  assign clock_out = out_q;

  // A burst keeps toggling only while its id is current; any newer edge or a
  // reset bumps burst_id_q, so a superseded burst silently stops at its next step.
  task automatic run_burst(input int unsigned id, input realtime half);
    out_q <= 1'b1;
    for (int i = 1; i < 2 * MULTIPLICATION; i++) begin
      #(half);
      if (id != burst_id_q) return;
      out_q <= ((i % 2) == 0);
    end
  endtask

  task automatic launch_burst(input int unsigned id, input realtime period);
    fork
      run_burst(id, period / (2.0 * MULTIPLICATION));
    join_none
  endtask

  always @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_UNLOCKED;
      period_q   <= 0.0;
      stamp_q    <= 0.0;
      burst_id_q <= burst_id_q + 1;
      out_q      <= 1'b0;
    end else if (state_q == ST_UNLOCKED) begin
      stamp_q <= $realtime;
      state_q <= ST_MEASURING;
    end else if ($realtime - stamp_q > 0.0) begin
      stamp_q    <= $realtime;
      period_q   <= $realtime - stamp_q;
      state_q    <= ST_LOCKED;
      burst_id_q <= burst_id_q + 1;
      launch_burst(burst_id_q + 1, $realtime - stamp_q);
    end else if (state_q == ST_LOCKED) begin
      // zero-length period from a glitch: keep the last good measurement
      burst_id_q <= burst_id_q + 1;
      launch_burst(burst_id_q + 1, period_q);
    end
  end

endmodule

// File: tb/tb_clock_frequency_multiplier.sv
// tb/tb_clock_frequency_multiplier.sv - scoreboard bench for clock_frequency_multiplier
`timescale 1ns/1fs
module tb_clock_frequency_multiplier;

  typedef struct {
    realtime rise;
    realtime width;
  } exp_t;

  logic        clk_in   = 1'b0;
  logic        resetn;
  bit          clk_run  = 1'b1;
  realtime     clk_half = 5.0;
  logic        cnt_clr  = 1'b0;
  logic [10:1] mout;
  logic [10:1][15:0] cnt_w;

  int      n_checks = 0;
  int      n_fail   = 0;
  exp_t    exp_q[$];
  exp_t    exp_new;
  exp_t    exp_cur;
  int      m_edges       = 0;
  realtime m_last        = 0.0;
  realtime model_p       = 0.0;
  realtime second_edge_t = -1.0;
  realtime first_rise_t  = -1.0;
  realtime last_rise_t   = 0.0;
  realtime exp_width     = 0.0;
  bit      have_width    = 1'b0;

  always begin
    #(clk_half);
    if (clk_run) clk_in = ~clk_in;
  end

  for (genvar gi = 1; gi <= 10; gi++) begin : g_mult
    logic [15:0] cnt;
    clock_frequency_multiplier #(.MULTIPLICATION(gi)) u_dut (
      .clock_in (clk_in),
      .resetn   (resetn),
      .clock_out(mout[gi])
    );
    always @(posedge mout[gi] or posedge cnt_clr) begin
      if (cnt_clr) cnt <= 16'd0;
      else         cnt <= cnt + 16'd1;
    end
    assign cnt_w[gi] = cnt;
  end

  function automatic real absdiff(input real a, input real b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Reference model for the M=4 instance: expected rise times and pulse widths.
  initial forever begin
    @(posedge clk_in or negedge resetn);
    if (resetn !== 1'b1) begin
      m_edges       = 0;
      second_edge_t = -1.0;
      exp_q.delete();
    end else begin
      if (m_edges >= 1) begin
        model_p = $realtime - m_last;
        while (exp_q.size() > 0 && exp_q[$].rise > $realtime - 1.0e-6) void'(exp_q.pop_back());
        for (int k = 0; k < 4; k++) begin
          exp_new.rise  = $realtime + k * model_p / 4.0;
          exp_new.width = model_p / 8.0;
          exp_q.push_back(exp_new);
        end
      end
      m_edges++;
      m_last = $realtime;
      if (m_edges == 2) second_edge_t = $realtime;
    end
  end

  initial forever begin
    @(posedge mout[4]);
    if (first_rise_t < 0.0) first_rise_t = $realtime;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      have_width = 1'b0;
      $display("FAIL rise_unexpected: clock_out rose at %0.6f ns, no rise expected", $realtime);
    end else begin
      exp_cur = exp_q.pop_front();
      if (absdiff($realtime, exp_cur.rise) > 1.0e-6) begin
        n_fail++;
        $display("FAIL rise_time: got %0.6f ns expected %0.6f ns", $realtime, exp_cur.rise);
      end
      last_rise_t = $realtime;
      exp_width   = exp_cur.width;
      have_width  = 1'b1;
    end
  end

  initial forever begin
    @(negedge mout[4]);
    if (have_width && resetn === 1'b1) begin
      n_checks++;
      if (absdiff($realtime - last_rise_t, exp_width) > 1.0e-6) begin
        n_fail++;
        $display("FAIL pulse_width: got %0.6f ns expected %0.6f ns", $realtime - last_rise_t, exp_width);
      end
    end
    have_width = 1'b0;
  end

  task automatic pulse_clear();
    cnt_clr = 1'b1;
    #0.1;
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      #0.5;
      n_checks++;
      if (mout !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got %b expected %b", mout, 10'b0);
      end
    end
    resetn       = 1'b1;
    first_rise_t = -1.0;
    @(posedge clk_in);
    #5.0;
    n_checks++;
    if (mout !== 10'b0 || first_rise_t >= 0.0) begin
      n_fail++;
      $display("FAIL pre_lock: got %b (first rise %0.6f) expected all low", mout, first_rise_t);
    end
    @(posedge clk_in);
    #1.0;
    n_checks++;
    if (first_rise_t < 0.0 || first_rise_t != second_edge_t) begin
      n_fail++;
      $display("FAIL lock_latency: first rise %0.6f ns expected %0.6f ns", first_rise_t, second_edge_t);
    end
  endtask

  task automatic test_burst_m4();
    repeat (6) @(posedge clk_in);
    #1.0;
    n_checks++;
    if (mout[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_high0: got %b expected 1", mout[4]);
    end
    #0.5;
    n_checks++;
    if (mout[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_low0: got %b expected 0", mout[4]);
    end
    #1.1;
    n_checks++;
    if (mout[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_high1: got %b expected 1", mout[4]);
    end
  endtask

  task automatic test_frequency();
    @(posedge clk_in);
    #9.5;
    pulse_clear();
    #999.9;
    for (int m = 1; m <= 10; m++) begin
      n_checks++;
      if (cnt_w[m] < 16'(95 * m) || cnt_w[m] > 16'(105 * m)) begin
        n_fail++;
        $display("FAIL freq_m%0d: got %0d rises per us expected %0d", m, cnt_w[m], 100 * m);
      end
    end
  endtask

  task automatic test_period_change();
    @(posedge clk_in);
    #0.1;
    clk_half = 10.0;
    repeat (3) @(posedge clk_in);
    @(posedge clk_in);
    #19.5;
    pulse_clear();
    #999.9;
    n_checks++;
    if (cnt_w[3] * 1000 < 148500 || cnt_w[3] * 1000 > 151500) begin
      n_fail++;
      $display("FAIL freq_change_m3: got %0d rises per us expected 150", cnt_w[3]);
    end
    @(posedge clk_in);
    #0.1;
    clk_half = 5.0;
    repeat (4) @(posedge clk_in);
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk_in);
    #1.0;
    resetn = 1'b0;
    #0.001;
    n_checks++;
    if (mout !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_immediate: got %b expected %b", mout, 10'b0);
    end
    pulse_clear();
    #30.0;
    for (int m = 1; m <= 10; m++) begin
      n_checks++;
      if (cnt_w[m] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_quiet_m%0d: got %0d rises expected 0", m, cnt_w[m]);
      end
    end
    @(negedge clk_in);
    resetn       = 1'b1;
    first_rise_t = -1.0;
    repeat (2) @(posedge clk_in);
    #1.0;
    n_checks++;
    if (first_rise_t < 0.0 || first_rise_t != second_edge_t) begin
      n_fail++;
      $display("FAIL relock_latency: first rise %0.6f ns expected %0.6f ns", first_rise_t, second_edge_t);
    end
  endtask

  task automatic test_stop();
    repeat (4) @(posedge clk_in);
    #0.1;
    clk_run = 1'b0;
    #20.0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stop_burst_complete: %0d rises still pending expected 0", exp_q.size());
    end
    n_checks++;
    if (mout !== 10'b0) begin
      n_fail++;
      $display("FAIL stop_idle: got %b expected %b", mout, 10'b0);
    end
    pulse_clear();
    #200.0;
    for (int m = 1; m <= 10; m++) begin
      n_checks++;
      if (cnt_w[m] !== 16'd0) begin
        n_fail++;
        $display("FAIL stop_freq_m%0d: got %0d rises expected 0", m, cnt_w[m]);
      end
    end
  endtask

  initial begin
    resetn = 1'b1;
    #1.0;
    resetn = 1'b0;
    test_reset();
    test_burst_m4();
    test_frequency();
    test_period_change();
    test_reset_mid_burst();
    test_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
